// File: rtl/barcode_id_rx_pkg.sv
// Shared types and constants for the barcode station-ID receiver.
// The frame-acceptance rule lives here so the top and any checker agree on it.
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_LOW = 3'd1,
    WAIT_FALL = 3'd2,
    BIT_WAIT  = 3'd3,
    CHECK     = 3'd4
  } bc_state_t;

  localparam int         ID_BITS         = 8;
  localparam logic [1:0] ID_VALID_PREFIX = 2'b00;

  // A station ID is only accepted when its two MSBs carry the valid prefix.
  function automatic logic id_prefix_ok(input logic [ID_BITS-1:0] v);
    return (v[ID_BITS-1 -: 2] == ID_VALID_PREFIX);
  endfunction

endpackage

// File: rtl/barcode_id_rx_sync_edge.sv
// Two-flop synchronizer for the barcode line plus an edge-detect flop.
// All flops reset high so that an idle line does not produce a spurious edge.
module bc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic bc,
  output logic cur,
  output logic fall,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= bc;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign cur  = sync_q;
  assign fall = prev_q & ~sync_q;
  assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/barcode_id_rx.sv
// Barcode station-ID receiver: measures the start-bit period, samples eight
// self-clocked data bits and publishes accepted IDs on a sticky ID/ID_vld pair.
module barcode_id_rx
  import bc_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                BC,
  input  logic                clr_ID_vld,
  output logic [ID_BITS-1:0]  ID,
  output logic                ID_vld,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_BIT = 4'd7;

  logic cur;
  logic fall;
  logic rise;

  bc_state_t            state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [CNT_W-1:0]     period_q,  period_d;
  logic [ID_BITS-1:0]   shft_q,    shft_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [ID_BITS-1:0]   id_q,      id_d;
  logic                 id_vld_q,  id_vld_d;
  logic                 busy_q,    busy_d;

  bc_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .bc   (BC),
    .cur  (cur),
    .fall (fall),
    .rise (rise)
  );

  // Next-state logic for the frame decoder and the ID handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    shft_d    = shft_q;
    bit_cnt_d = bit_cnt_q;
    id_d      = id_q;
    if (clr_ID_vld) begin
      id_vld_d = 1'b0;
    end else begin
      id_vld_d = id_vld_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (fall) begin
          bit_cnt_d = 4'd0;
          state_d   = START_LOW;
        end else begin
          state_d   = IDLE;
        end
      end
      START_LOW: begin
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = CNT_ZERO;
          state_d  = WAIT_FALL;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d    = CNT_ZERO;
          state_d  = IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          cnt_d   = CNT_ZERO;
          state_d = BIT_WAIT;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      BIT_WAIT: begin
        // cnt restarts on the edge cycle, so this lands period+1 clocks after it.
        if (cnt_q == period_q) begin
          shft_d    = {shft_q[ID_BITS-2:0], cur};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = CNT_ZERO;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = CHECK;
          end else begin
            state_d = WAIT_FALL;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        state_d = IDLE;
        // A set here wins over a simultaneous clear.
        if (id_prefix_ok(shft_q)) begin
          id_d     = shft_q;
          id_vld_d = 1'b1;
        end else begin
          id_d     = id_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Decoder and handshake state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      shft_q    <= {ID_BITS{1'b0}};
      bit_cnt_q <= 4'd0;
      id_q      <= {ID_BITS{1'b0}};
      id_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      shft_q    <= shft_d;
      bit_cnt_q <= bit_cnt_d;
      id_q      <= id_d;
      id_vld_q  <= id_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign ID     = id_q;
  assign ID_vld = id_vld_q;
  assign busy   = busy_q;

endmodule
